// File: rtl/axis_eth_fcs_strip_64_pkg.sv
// Shared definitions for the 64-bit Ethernet FCS stripper: bus widths,
// FCS length, state encoding and tkeep <-> byte-count helpers.
package axis_eth_fcs_strip_64_pkg;

   localparam int DATA_WIDTH = 64;
   localparam int KEEP_WIDTH = 8;
   localparam int FCS_LEN    = 4;

   typedef enum logic [1:0] {
      STATE_IDLE = 2'd0,
      STATE_HOLD = 2'd1,
      STATE_LAST = 2'd2
   } state_t;

   // Byte count of a beat: index of the highest set keep bit plus one.
   // Bits above a gap are still counted.
   function automatic logic [3:0] keep_to_count(input logic [KEEP_WIDTH-1:0] keep);
      logic [3:0] cnt;
      cnt = 4'd0;
      for (int i = 0; i < KEEP_WIDTH; i++) begin
         if (keep[i]) cnt = 4'(i + 1);
      end
      return cnt;
   endfunction

   // Contiguous low-aligned keep mask for a byte count of 0..8.
   function automatic logic [KEEP_WIDTH-1:0] count_to_keep(input logic [3:0] cnt);
      logic [KEEP_WIDTH:0] ones;
      ones = (9'd1 << cnt) - 9'd1;
      return ones[KEEP_WIDTH-1:0];
   endfunction

endpackage

// File: rtl/axis_out_reg_64.sv
// Two-entry (output + temp) AXI4-Stream register for 64-bit stages.
// Outputs never depend combinationally on m_axis_tready. The upstream stage
// may present in_tvalid only while in_tready (registered early-ready) is high.
module axis_out_reg_64
   import axis_eth_fcs_strip_64_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] in_tdata,
   input  logic [KEEP_WIDTH-1:0] in_tkeep,
   input  logic                  in_tvalid,
   input  logic                  in_tlast,
   input  logic                  in_tuser,
   output logic                  in_tready,
   output logic                  in_tready_early,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic                  m_axis_tuser
);

   logic [DATA_WIDTH-1:0] temp_tdata;
   logic [KEEP_WIDTH-1:0] temp_tkeep;
   logic                  temp_tlast, temp_tuser;
   logic                  m_valid_reg, temp_valid_reg, ready_reg;
   logic                  m_valid_next, temp_valid_next;
   logic                  store_in_to_out, store_in_to_temp, store_temp_to_out;

   // Ready for next cycle if the sink drains, or temp stays empty and the
   // output slot is free or not being filled now.
   assign in_tready_early = m_axis_tready || (!temp_valid_reg && (!m_valid_reg || !in_tvalid));
   assign in_tready       = ready_reg;
   assign m_axis_tvalid   = m_valid_reg;

   // Steering: where the incoming beat (or the temp beat) goes this cycle.
   always_comb begin
      m_valid_next      = m_valid_reg;
      temp_valid_next   = temp_valid_reg;
      store_in_to_out   = 1'b0;
      store_in_to_temp  = 1'b0;
      store_temp_to_out = 1'b0;
      if (ready_reg) begin
         if (m_axis_tready || !m_valid_reg) begin
            m_valid_next    = in_tvalid;
            store_in_to_out = 1'b1;
         end else begin
            temp_valid_next  = in_tvalid;
            store_in_to_temp = 1'b1;
         end
      end else if (m_axis_tready) begin
         m_valid_next      = temp_valid_reg;
         temp_valid_next   = 1'b0;
         store_temp_to_out = 1'b1;
      end
   end

   // Register update: valids/ready with reset, payload moved per steering.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_valid_reg    <= 1'b0;
         temp_valid_reg <= 1'b0;
         ready_reg      <= 1'b0;
         m_axis_tlast   <= 1'b0;
         m_axis_tuser   <= 1'b0;
      end else begin
         m_valid_reg    <= m_valid_next;
         temp_valid_reg <= temp_valid_next;
         ready_reg      <= in_tready_early;
         if (store_in_to_out) begin
            m_axis_tdata <= in_tdata;
            m_axis_tkeep <= in_tkeep;
            m_axis_tlast <= in_tlast;
            m_axis_tuser <= in_tuser;
         end else if (store_temp_to_out) begin
            m_axis_tdata <= temp_tdata;
            m_axis_tkeep <= temp_tkeep;
            m_axis_tlast <= temp_tlast;
            m_axis_tuser <= temp_tuser;
         end
         if (store_in_to_temp) begin
            temp_tdata <= in_tdata;
            temp_tkeep <= in_tkeep;
            temp_tlast <= in_tlast;
            temp_tuser <= in_tuser;
         end
      end
   end

endmodule

// File: rtl/axis_eth_fcs_strip_64.sv
// Removes the trailing 4-byte FCS from 64-bit AXI4-Stream Ethernet frames.
// One beat of lookahead (d0) lets the FCS be trimmed when it straddles a
// beat boundary. The frame error flag moves to the new last beat; frames
// with no payload left become a one-byte errored beat plus an error_runt pulse.
// Handshake: a beat transfers on a rising clk edge where tvalid && tready.
module axis_eth_fcs_strip_64
   import axis_eth_fcs_strip_64_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   input  logic                  s_axis_tuser,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic                  m_axis_tuser,
   output logic                  busy,
   output logic                  error_runt
);

   state_t                state_reg, state_next;
   logic [DATA_WIDTH-1:0] d0_reg, d0_next;
   logic [KEEP_WIDTH-1:0] last_keep_reg, last_keep_next;
   logic                  held_tuser_reg, held_tuser_next;
   logic                  s_tready_reg, busy_reg, runt_reg, runt_next;
   logic [DATA_WIDTH-1:0] int_tdata;
   logic [KEEP_WIDTH-1:0] int_tkeep;
   logic                  int_tvalid, int_tlast, int_tuser;
   logic                  int_tready, int_tready_early;
   logic [3:0]            in_count;
   logic                  accept;

   assign in_count      = keep_to_count(s_axis_tkeep);
   assign accept        = s_axis_tvalid && s_tready_reg;
   assign s_axis_tready = s_tready_reg;
   assign busy          = busy_reg;
   assign error_runt    = runt_reg;

   // Next-state and output-register write logic.
   always_comb begin
      state_next      = state_reg;
      d0_next         = d0_reg;
      last_keep_next  = last_keep_reg;
      held_tuser_next = held_tuser_reg;
      runt_next       = 1'b0;
      int_tdata       = '0;
      int_tkeep       = '0;
      int_tvalid      = 1'b0;
      int_tlast       = 1'b0;
      int_tuser       = 1'b0;
      case (state_reg)
         STATE_IDLE: begin
            if (accept) begin
               if (!s_axis_tlast) begin
                  d0_next         = s_axis_tdata;
                  held_tuser_next = s_axis_tuser;
                  state_next      = STATE_HOLD;
               end else if (in_count > 4'(FCS_LEN)) begin
                  // Single-beat frame: only the beat itself remains to send.
                  d0_next         = s_axis_tdata;
                  last_keep_next  = count_to_keep(in_count - 4'(FCS_LEN));
                  held_tuser_next = s_axis_tuser;
                  state_next      = STATE_LAST;
               end else begin
                  // Nothing survives stripping: emit a one-byte errored beat.
                  int_tkeep       = 8'h01;
                  int_tvalid      = 1'b1;
                  int_tlast       = 1'b1;
                  int_tuser       = 1'b1;
                  runt_next       = 1'b1;
                  held_tuser_next = 1'b0;
               end
            end
         end
         STATE_HOLD: begin
            if (accept) begin
               int_tdata  = d0_reg;
               int_tkeep  = 8'hFF;
               int_tvalid = 1'b1;
               if (!s_axis_tlast) begin
                  d0_next         = s_axis_tdata;
                  held_tuser_next = held_tuser_reg | s_axis_tuser;
               end else if (in_count > 4'(FCS_LEN)) begin
                  d0_next         = s_axis_tdata;
                  last_keep_next  = count_to_keep(in_count - 4'(FCS_LEN));
                  held_tuser_next = held_tuser_reg | s_axis_tuser;
                  state_next      = STATE_LAST;
               end else begin
                  // FCS lies partly/fully in this beat: held beat ends the frame.
                  int_tkeep       = count_to_keep(in_count + 4'(FCS_LEN));
                  int_tlast       = 1'b1;
                  int_tuser       = held_tuser_reg | s_axis_tuser;
                  held_tuser_next = 1'b0;
                  state_next      = STATE_IDLE;
               end
            end
         end
         STATE_LAST: begin
            if (int_tready) begin
               int_tdata       = d0_reg;
               int_tkeep       = last_keep_reg;
               int_tvalid      = 1'b1;
               int_tlast       = 1'b1;
               int_tuser       = held_tuser_reg;
               held_tuser_next = 1'b0;
               state_next      = STATE_IDLE;
            end
         end
         default: state_next = STATE_IDLE;
      endcase
   end

   // State, lookahead beat and registered control outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= STATE_IDLE;
         held_tuser_reg <= 1'b0;
         s_tready_reg   <= 1'b0;
         busy_reg       <= 1'b0;
         runt_reg       <= 1'b0;
         last_keep_reg  <= '0;
      end else begin
         state_reg      <= state_next;
         held_tuser_reg <= held_tuser_next;
         s_tready_reg   <= int_tready_early && (state_next != STATE_LAST);
         busy_reg       <= (state_next != STATE_IDLE);
         runt_reg       <= runt_next;
         last_keep_reg  <= last_keep_next;
         d0_reg         <= d0_next;
      end
   end

   axis_out_reg_64 u_out_reg (
      .clk             (clk),
      .rst             (rst),
      .in_tdata        (int_tdata),
      .in_tkeep        (int_tkeep),
      .in_tvalid       (int_tvalid),
      .in_tlast        (int_tlast),
      .in_tuser        (int_tuser),
      .in_tready       (int_tready),
      .in_tready_early (int_tready_early),
      .m_axis_tdata    (m_axis_tdata),
      .m_axis_tkeep    (m_axis_tkeep),
      .m_axis_tvalid   (m_axis_tvalid),
      .m_axis_tready   (m_axis_tready),
      .m_axis_tlast    (m_axis_tlast),
      .m_axis_tuser    (m_axis_tuser)
   );

endmodule

// File: doc/axis_eth_fcs_strip_64.md
# axis_eth_fcs_strip_64

AXI4-Stream Ethernet FCS stripper with a 64-bit datapath. It sits directly downstream of the 64-bit FCS checker, which passes frames through with the 4-byte FCS still attached and the error flag on tuser. This block removes the trailing 4 FCS bytes, carries the frame error flag to the new last beat, and flags frames that have no payload left after stripping. It holds one beat of lookahead so that it can trim the FCS when it spans a beat boundary.

## Interface
- No parameters. Fixed values: DATA_WIDTH 64, KEEP_WIDTH 8, FCS_LEN 4.
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- s_axis_tdata  in  64  input data, byte 0 in bits [7:0]
- s_axis_tkeep  in  8  byte enables; must be 8'hFF on non-last beats
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready (registered)
- s_axis_tlast  in  1  end of frame
- s_axis_tuser  in  1  frame error (bad FCS or upstream error)
- m_axis_tdata  out  64  output data
- m_axis_tkeep  out  8  output byte enables
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  output end of frame
- m_axis_tuser  out  1  output frame error
- busy  out  1  high while a frame is in progress
- error_runt  out  1  one-cycle pulse when a frame has 0 payload bytes after stripping

## Operation
- **Last-beat byte count n:** n = index of the highest set bit of tkeep + 1, giving 1..8. Set bits above a gap are counted.
- **States:** IDLE (nothing held), HOLD (one beat held in the d0 register), LAST (emitting the trimmed final beat; input stalled).
- **IDLE, non-last beat accepted:** store the beat in d0 and go to HOLD. Nothing is output.
- **HOLD, non-last beat accepted:** output d0 with tlast=0, tuser=0 and keep 8'hFF. Store the new beat in d0.
- **Last beat accepted with n>4, in HOLD:**
  - Output d0 as a non-last beat.
  - Latch keep = (1<<(n-4))-1 and tuser = s_axis_tuser | held_tuser.
  - Drop s_axis_tready and go to LAST.
  - LAST emits the accepted beat with that keep and tlast=1, then returns to IDLE.
- **Last beat accepted with n>4, in IDLE (single-beat frame):** go to LAST the same way. No held beat is output.
- **Last beat accepted with n≤4, in HOLD:** output d0 as the last beat.
  - keep = (1<<(4+n))-1.
  - tuser = s_axis_tuser | held_tuser.
  - The accepted beat is discarded. Return to IDLE.
- **Last beat accepted with n≤4, in IDLE (runt):** output one beat with data 0, keep 8'h01, tlast=1, tuser=1. Pulse error_runt. Stay in IDLE.
- **held_tuser:** OR of tuser over all beats already accepted in the current frame. Cleared at the end of each frame.
- **Output register:** a two-entry output register with temp storage, so m_axis_* never combinationally depends on m_axis_tready.
- **busy:** registered, equal to (state_next != IDLE).

## Timing
- Reset values: s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, busy=0, error_runt=0, state=IDLE, held_tuser=0.
- s_axis_tready is 0 in the first cycle after rst falls. From then on it follows the output-register early-ready, registered.
- Latency: input beat k appears on m_axis_* 1 cycle after beat k+1 (or the frame's last beat) is accepted.
- Runt frames: 1 cycle after acceptance.
- LAST costs exactly one extra cycle (input stalled) when m_axis_tready is held high. Under backpressure the block stays in LAST until the beat is taken by the output register.
- Back-to-back frames: the first beat of frame N+1 can be accepted in the cycle after LAST exits, or in the cycle after an n≤4 last beat.
- Throughput: 1 beat/cycle, except for the single LAST stall per frame with n>4.
- rst mid-frame: held beat, LAST state and output registers are all discarded. No partial tlast is emitted.

## Structure
- Shared package/header holds:
  - state encodings (2-bit: IDLE=0, HOLD=1, LAST=2);
  - FCS_LEN=4;
  - a keep-to-count function and a count-to-keep function.
- One sub-module, axis_out_reg_64: the skid/temp output register providing m_axis_tready_int_early. It is reused by neighbouring 64-bit stages.

## Test plan
- 64-byte frame: 8 full beats, last keep 8'hFF, tuser=0 → 8 output beats; last beat keep 8'h0F, tlast=1, tuser=0; bytes 0..59 intact.
- 65-byte frame: last beat keep 8'h01 → 8 output beats; beat 8 keep 8'h1F, tlast=1; the 9th input beat is absent from the output.
- 60-byte frame with tuser=1 on the last beat (keep 8'h0F) → 7 output beats; last keep 8'hFF, tuser=1.
- 4-byte frame: single beat, keep 8'h0F → one beat with keep 8'h01, tuser=1, tlast=1; error_runt pulses for exactly 1 cycle.
- Random frames of 5..200 bytes with m_axis_tready toggling 1,0,0,1 and random s_axis_tvalid gaps → output byte stream equals input minus the last 4 bytes per frame; no duplicated or lost beats.
- rst asserted for 1 cycle while in HOLD mid-frame, followed by a new 64-byte frame → no output from the aborted frame; the new frame is output exactly as in the first scenario.
